// File: rtl/row_pipeline_ctrl.sv
// row_pipeline_ctrl
// Sequences one row at a time between the pixel CDC FIFO (FWFT), the SDRAM
// facade and the compressor. For each row it writes FrameWidth current-frame
// pixels to the facade, then reads back the matching previous-frame row in
// bursts, then hands the row pair to the compressor. The previous-frame read
// is skipped while no valid reference frame exists. Corrupt frames, caused by
// FIFO overflow or an early frame start, are counted and invalidate the
// reference.
//
// Handshake semantics: every strobe (o_fifo_rd, o_wr_req, o_rd_req, o_row_done)
// is a registered single-cycle pulse. A request is only issued on a clock edge
// where the matching busy input is low and the strobe itself is not already
// high, so a busy change is always re-sampled before the next request.
// i_rd_valid and i_comp_ready are single-cycle pulses from the sinks, each
// accepted on the edge where it is high. The FIFO is first-word-fall-through:
// i_fifo_pixel is valid whenever i_fifo_empty is low, and o_fifo_rd pops it.
module row_pipeline_ctrl #(
    parameter int FrameWidth         = 640,
    parameter int FrameHeight        = 480,
    parameter int PixelBitWidth      = 16,
    parameter int BurstLength        = 8,
    parameter int DropCntWidth       = 8,
    parameter int FlushBetweenFrames = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           i_frame_start,
    input  logic                           i_fifo_empty,
    input  logic                           i_fifo_full,
    input  logic [PixelBitWidth-1:0]       i_fifo_pixel,
    output logic                           o_fifo_rd,
    output logic                           o_wr_req,
    output logic [PixelBitWidth-1:0]       o_wr_pixel,
    input  logic                           i_wr_busy,
    output logic                           o_rd_req,
    input  logic                           i_rd_busy,
    input  logic                           i_rd_valid,
    output logic                           o_row_done,
    input  logic                           i_comp_ready,
    output logic [$clog2(FrameHeight)-1:0] o_row_idx,
    output logic                           o_first_frame,
    output logic [DropCntWidth-1:0]        o_drop_cnt,
    output logic                           o_busy,
    output logic [1:0]                     o_state
);

    localparam int CntW = $clog2(FrameWidth + 1);
    localparam int RowW = $clog2(FrameHeight);
    localparam logic [CntW-1:0] RowPixels = CntW'(FrameWidth);
    localparam logic [CntW-1:0] BurstInc  = CntW'(BurstLength);
    localparam logic [RowW-1:0] LastRow   = RowW'(FrameHeight - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WRITE_ROW  = 2'd1,
        READ_ROW   = 2'd2,
        HANDOFF    = 2'd3
    } state_t;

    state_t          state;
    logic [CntW-1:0] wrCnt;
    logic [CntW-1:0] rqCnt;
    logic [CntW-1:0] rvCnt;
    logic            sofPending;
    logic            corrupt;

    // State is exposed for debug; busy is a decode of the state register.
    assign o_state = state;
    assign o_busy  = (state != WAIT_FRAME);

    // Row sequencer: state, counters, frame bookkeeping and registered strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= WAIT_FRAME;
            wrCnt         <= '0;
            rqCnt         <= '0;
            rvCnt         <= '0;
            sofPending    <= 1'b0;
            corrupt       <= 1'b0;
            o_fifo_rd     <= 1'b0;
            o_wr_req      <= 1'b0;
            o_wr_pixel    <= '0;
            o_rd_req      <= 1'b0;
            o_row_done    <= 1'b0;
            o_row_idx     <= '0;
            o_first_frame <= 1'b1;
            o_drop_cnt    <= '0;
        end else begin
            o_fifo_rd  <= 1'b0;
            o_wr_req   <= 1'b0;
            o_rd_req   <= 1'b0;
            o_row_done <= 1'b0;

            // A frame start that arrives mid-frame is remembered so the next
            // frame is not lost, and marks the current frame as corrupt.
            if (state != WAIT_FRAME) begin
                if (i_frame_start) begin
                    sofPending <= 1'b1;
                end
                if (i_fifo_full || i_frame_start) begin
                    corrupt <= 1'b1;
                end
            end

            case (state)
                WAIT_FRAME: begin
                    if (i_frame_start || sofPending) begin
                        corrupt    <= 1'b0;
                        sofPending <= 1'b0;
                        wrCnt      <= '0;
                        state      <= WRITE_ROW;
                    end else if ((FlushBetweenFrames != 0) && !i_fifo_empty) begin
                        // Stale pixels from a partial frame are discarded.
                        o_fifo_rd <= 1'b1;
                    end
                end

                WRITE_ROW: begin
                    if (wrCnt == RowPixels) begin
                        if (o_first_frame) begin
                            o_row_done <= 1'b1;
                            state      <= HANDOFF;
                        end else begin
                            rqCnt <= '0;
                            rvCnt <= '0;
                            state <= READ_ROW;
                        end
                    end else if (!i_fifo_empty && !i_wr_busy && !o_wr_req) begin
                        // The !o_wr_req term leaves one idle cycle per pixel so
                        // the FIFO head and the facade busy flag settle.
                        o_fifo_rd  <= 1'b1;
                        o_wr_req   <= 1'b1;
                        o_wr_pixel <= i_fifo_pixel;
                        wrCnt      <= wrCnt + 1'b1;
                    end
                end

                READ_ROW: begin
                    if (rvCnt == RowPixels) begin
                        o_row_done <= 1'b1;
                        state      <= HANDOFF;
                    end else begin
                        if (i_rd_valid) begin
                            rvCnt <= rvCnt + 1'b1;
                        end
                        if (!i_rd_busy && !o_rd_req && (rqCnt < RowPixels)) begin
                            o_rd_req <= 1'b1;
                            rqCnt    <= rqCnt + BurstInc;
                        end
                    end
                end

                HANDOFF: begin
                    if (i_comp_ready) begin
                        if (o_row_idx < LastRow) begin
                            o_row_idx <= o_row_idx + 1'b1;
                            wrCnt     <= '0;
                            state     <= WRITE_ROW;
                        end else begin
                            o_row_idx <= '0;
                            state     <= WAIT_FRAME;
                            // A corrupt frame is not a usable reference.
                            if (corrupt) begin
                                if (o_drop_cnt != {DropCntWidth{1'b1}}) begin
                                    o_drop_cnt <= o_drop_cnt + 1'b1;
                                end
                                o_first_frame <= 1'b1;
                            end else begin
                                o_first_frame <= 1'b0;
                            end
                        end
                    end
                end

                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_row_pipeline_ctrl.sv
// Bench for row_pipeline_ctrl with an 8x2 frame and 4-pixel bursts.
module tb_row_pipeline_ctrl;

    localparam int FW = 8;
    localparam int FH = 2;
    localparam int BL = 4;
    localparam int PW = 16;
    localparam int DW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_frame_start = 1'b0;
    logic          i_fifo_empty;
    logic          i_fifo_full = 1'b0;
    logic [PW-1:0] i_fifo_pixel;
    logic          o_fifo_rd;
    logic          o_wr_req;
    logic [PW-1:0] o_wr_pixel;
    logic          i_wr_busy = 1'b0;
    logic          o_rd_req;
    logic          i_rd_busy = 1'b0;
    logic          i_rd_valid = 1'b0;
    logic          o_row_done;
    logic          i_comp_ready = 1'b0;
    logic          o_row_idx;
    logic          o_first_frame;
    logic [DW-1:0] o_drop_cnt;
    logic          o_busy;
    logic [1:0]    o_state;

    row_pipeline_ctrl #(
        .FrameWidth(FW), .FrameHeight(FH), .PixelBitWidth(PW),
        .BurstLength(BL), .DropCntWidth(DW), .FlushBetweenFrames(1)
    ) dut (
        .CLK(CLK), .RST(RST), .i_frame_start(i_frame_start),
        .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full),
        .i_fifo_pixel(i_fifo_pixel), .o_fifo_rd(o_fifo_rd),
        .o_wr_req(o_wr_req), .o_wr_pixel(o_wr_pixel), .i_wr_busy(i_wr_busy),
        .o_rd_req(o_rd_req), .i_rd_busy(i_rd_busy), .i_rd_valid(i_rd_valid),
        .o_row_done(o_row_done), .i_comp_ready(i_comp_ready),
        .o_row_idx(o_row_idx), .o_first_frame(o_first_frame),
        .o_drop_cnt(o_drop_cnt), .o_busy(o_busy), .o_state(o_state)
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // FWFT FIFO model: main process advances wrPtr, this block advances rdPtr.
    logic [PW-1:0] pixMem [0:255];
    logic [7:0]    wrPtr = 8'd0;
    logic [7:0]    rdPtr = 8'd0;
    assign i_fifo_empty = (rdPtr == wrPtr);
    assign i_fifo_pixel = pixMem[rdPtr];
    always @(posedge CLK) begin
        if (o_fifo_rd && (rdPtr != wrPtr)) rdPtr <= rdPtr + 8'd1;
    end

    // Scoreboard state
    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int wrSeen = 0;
    int rdReqCnt = 0;
    int rowDoneCnt = 0;
    int rdPending = 0;

    typedef struct {
        int base;
        int fullRow;
        int busyRow;
        int expRdReq;
        int expDrop;
        int expFirst;
    } frame_vec_t;
    frame_vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge and run the monitor / facade read model.
    task automatic tick();
        @(negedge CLK);
        if (!RST) begin
            rdPending  = 0;
            i_rd_valid = 1'b0;
        end else begin
            if (o_wr_req) begin
                wrSeen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr pixel=%0h t=%0t", o_wr_pixel, $time);
                end else begin
                    check("wr_pixel", int'(o_wr_pixel), int'(exp_q.pop_front()));
                end
            end
            if (i_wr_busy) check("no_rd_wr_while_busy", int'(o_wr_req | o_fifo_rd), 0);
            if (o_rd_req) begin
                rdReqCnt++;
                rdPending += BL;
            end
            if (o_row_done) rowDoneCnt++;
            if (rdPending > 0) begin
                i_rd_valid = 1'b1;
                rdPending--;
            end else begin
                i_rd_valid = 1'b0;
            end
        end
    endtask

    task automatic push_frame_pixels(input int base);
        for (int i = 0; i < FW * FH; i++) begin
            pixMem[wrPtr] = PW'(base + i);
            exp_q.push_back(PW'(base + i));
            wrPtr = wrPtr + 8'd1;
        end
    endtask

    task automatic start_frame(input int base);
        i_frame_start = 1'b1;
        push_frame_pixels(base);
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic wait_row_done(input int row, input int fullRow, input int busyRow, input int wrBase);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (o_row_done) seen = 1'b1;
            i_fifo_full = (row == fullRow) && (n == 3);
            i_wr_busy   = (row == busyRow) && (n >= 6) && (n < 11);
        end
        i_fifo_full = 1'b0;
        i_wr_busy   = 1'b0;
        check("row_done_seen", int'(seen), 1);
        check("row_idx", int'(o_row_idx), row);
        check("writes_so_far", wrSeen - wrBase, FW * (row + 1));
    endtask

    task automatic release_row(input bit withStart);
        tick();
        tick();
        i_comp_ready  = 1'b1;
        i_frame_start = withStart;
        tick();
        i_comp_ready  = 1'b0;
        i_frame_start = 1'b0;
    endtask

    task automatic end_checks(input int rdBase, input int doneBase, input frame_vec_t v);
        check("busy_end", int'(o_busy), 0);
        check("row_idx_end", int'(o_row_idx), 0);
        check("first_frame", int'(o_first_frame), v.expFirst);
        check("drop_cnt", int'(o_drop_cnt), v.expDrop);
        check("rd_req_cnt", rdReqCnt - rdBase, v.expRdReq);
        check("row_done_cnt", rowDoneCnt - doneBase, FH);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic run_frame(input frame_vec_t v);
        int wrBase, rdBase, doneBase;
        wrBase = wrSeen;
        rdBase = rdReqCnt;
        doneBase = rowDoneCnt;
        start_frame(v.base);
        check("busy_after_start", int'(o_busy), 1);
        for (int row = 0; row < FH; row++) begin
            wait_row_done(row, v.fullRow, v.busyRow, wrBase);
            release_row(1'b0);
        end
        end_checks(rdBase, doneBase, v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int wrBase, rdBase, doneBase, n;
        frame_vec_t v;

        //               base    fullRow busyRow rdReq drop first
        vecs[0] = '{32'h0001, -1, -1, 0, 0, 0}; // first frame, no reads
        vecs[1] = '{32'h0101, -1,  0, 4, 0, 0}; // clean, busy stall in row 0
        vecs[2] = '{32'h0201,  1, -1, 4, 1, 1}; // overflow in row 1
        vecs[3] = '{32'h0301, -1, -1, 0, 1, 0}; // reference invalid, no reads
        vecs[4] = '{32'h0401,  1, -1, 4, 2, 1};
        vecs[5] = '{32'h0501,  0, -1, 0, 3, 1};
        vecs[6] = '{32'h0601,  1, -1, 0, 3, 1}; // counter saturates
        vecs[7] = '{32'h0701, -1, -1, 0, 3, 0};

        // Reset state
        tick();
        tick();
        check("rst_first_frame", int'(o_first_frame), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_drop", int'(o_drop_cnt), 0);
        check("rst_row_idx", int'(o_row_idx), 0);
        check("rst_strobes", int'({o_fifo_rd, o_wr_req, o_rd_req, o_row_done}), 0);
        RST = 1'b1;
        tick();

        // Stale FIFO contents are flushed while idle and never written
        for (int i = 0; i < 3; i++) begin
            pixMem[wrPtr] = PW'(16'hDEAD);
            wrPtr = wrPtr + 8'd1;
        end
        wrBase = wrSeen;
        for (int i = 0; i < 8; i++) tick();
        check("flush_empty", int'(i_fifo_empty), 1);
        check("flush_no_wr", wrSeen - wrBase, 0);
        check("flush_idle", int'(o_busy), 0);

        // Table of whole frames
        for (int k = 0; k < 8; k++) run_frame(vecs[k]);

        // Frame start coincident with the final compressor ready
        wrBase = wrSeen;
        rdBase = rdReqCnt;
        doneBase = rowDoneCnt;
        start_frame(32'h0801);
        wait_row_done(0, -1, -1, wrBase);
        release_row(1'b0);
        wait_row_done(1, -1, -1, wrBase);
        release_row(1'b1);
        check("coinc_idle_cycle", int'(o_busy), 0);
        v = '{32'h0801, -1, -1, 4, 3, 0};
        end_checks(rdBase, doneBase, v);
        wrBase = wrSeen;
        rdBase = rdReqCnt;
        doneBase = rowDoneCnt;
        push_frame_pixels(32'h0901);
        tick();
        check("coinc_write_entered", int'(o_busy), 1);
        for (int row = 0; row < FH; row++) begin
            wait_row_done(row, -1, -1, wrBase);
            release_row(1'b0);
        end
        v = '{32'h0901, -1, -1, 4, 3, 0};
        end_checks(rdBase, doneBase, v);

        // Asynchronous reset in the middle of READ_ROW
        rdBase = rdReqCnt;
        start_frame(32'h0a01);
        n = 0;
        while (rdReqCnt == rdBase && n < 100) begin
            tick();
            n++;
        end
        check("rd_req_before_reset", int'(rdReqCnt != rdBase), 1);
        #2;
        RST = 1'b0;
        #1;
        check("mid_rst_first_frame", int'(o_first_frame), 1);
        check("mid_rst_drop", int'(o_drop_cnt), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_strobes", int'({o_fifo_rd, o_wr_req, o_rd_req, o_row_done}), 0);
        exp_q.delete();
        wrPtr = rdPtr;
        tick();
        tick();
        RST = 1'b1;
        tick();

        // A normal first frame after reset
        v = '{32'h0b01, -1, -1, 0, 0, 0};
        run_frame(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
